// File: rtl/multicycle_divider_pkg.sv
// Shared definitions for the multicycle divider.
// The state encodings are exposed both as macros (for the hazard unit and any
// other consumer that only needs the raw codes) and as a typed enum in the
// package. The guard makes repeated inclusion of this file harmless.
`ifndef MULTICYCLE_DIVIDER_PKG_SV
`define MULTICYCLE_DIVIDER_PKG_SV

`define DIV_ST_IDLE 2'd0
`define DIV_ST_RUN  2'd1
`define DIV_ST_FIX  2'd2
`define DIV_ST_DONE 2'd3

package multicycle_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `DIV_ST_IDLE,
    ST_RUN  = `DIV_ST_RUN,
    ST_FIX  = `DIV_ST_FIX,
    ST_DONE = `DIV_ST_DONE
  } div_state_t;

endpackage

`endif

// File: rtl/multicycle_divider_sign_fix.sv
// div_sign_fix: combinational two's-complement helper.
// Ports:
//   val  in   WIDTH  value to pass through or negate
//   neg  in   1      negate when high
//   res  out  WIDTH  val or -val
// Taking the magnitude of a negative operand and re-applying a sign to a
// result are the same operation, so one helper serves both load and fix-up.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/multicycle_divider.sv
// multicycle_divider: restoring shift-subtract divider, one quotient bit per
// clock, signed (DIV) or unsigned (DIVU).
// Ports:
//   clock        in   1      rising-edge clock
//   reset        in   1      asynchronous active-high reset
//   start        in   1      request a division (accepted in IDLE/DONE only)
//   is_signed    in   1      two's-complement operands when high
//   dividend     in   WIDTH  numerator, sampled with start
//   divisor      in   WIDTH  denominator, sampled with start
//   flush        in   1      abort; wins over a simultaneous start
//   busy         out  1      high in RUN and FIX (stall request)
//   done         out  1      one-cycle pulse while in DONE
//   quotient     out  WIDTH  result for LO, held until the next FIX
//   remainder    out  WIDTH  result for HI, held until the next FIX
//   div_by_zero  out  1      latched divisor was zero
// Latency: start edge is edge 0, WIDTH steps on edges 1..WIDTH, sign fix on
// edge WIDTH+1, done high in the following cycle.
module multicycle_divider
  import multicycle_divider_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;      // partial remainder, always < divisor magnitude
  logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH-1:0] dvd_q;      // original dividend, returned on divide by zero
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;

  logic             sgn;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
  logic [WIDTH:0]   shifted, diff;

  assign sgn       = SIGNED_EN & is_signed;
  assign accept    = start & ~flush & ((state == ST_IDLE) | (state == ST_DONE));
  assign last_step = (cnt == CW'(1));

  // WIDTH+1-bit trial subtraction: shifted can reach 2*divisor-1, and the
  // top bit of diff is the borrow that decides the quotient bit.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_dvd (
    .val(dividend), .neg(sgn & dividend[WIDTH-1]), .res(dvd_mag));
  div_sign_fix #(.WIDTH(WIDTH)) u_mag_dvs (
    .val(divisor),  .neg(sgn & divisor[WIDTH-1]),  .res(dvs_mag));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .val(quo_q),    .neg(neg_quo_q),               .res(quo_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .val(rem_q),    .neg(neg_rem_q),               .res(rem_fix));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = accept ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        dvd_q     <= dividend;
        dvs_q     <= dvs_mag;
        quo_q     <= dvd_mag;
        rem_q     <= '0;
        cnt       <= CW'(WIDTH);
        neg_quo_q <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_rem_q <= sgn & dividend[WIDTH-1];
        dz_q      <= (divisor == '0);
      end else if (state == ST_RUN) begin
        cnt   <= cnt - CW'(1);
        rem_q <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      end
      // A flush on the fix-up edge must leave the previous results visible.
      if (state == ST_FIX && !flush) begin
        quotient    <= dz_q ? '1    : quo_fix;
        remainder   <= dz_q ? dvd_q : rem_fix;
        div_by_zero <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_divider.sv
// Self-checking bench for multicycle_divider (WIDTH=32, SIGNED_EN=1).
// Expected results come from plain 64-bit integer division in the bench.
module tb_multicycle_divider;
  import multicycle_divider_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] last_q, last_r;
  logic         last_dz;

  multicycle_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush), .busy(busy),
    .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Drives a start and takes edge 0.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    tick;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    chk("busy_e0", W'(busy), W'(1));
  endtask

  // Edges 1..W+1 after start_op. inj>0 offers a 9/3 start before edge inj,
  // which must be ignored. linger takes one more edge and checks the hold.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                           input int inj, input bit linger);
    logic [W-1:0] eq, er;
    bit           edz;
    model(a, b, s, eq, er, edz);
    for (int k = 1; k <= W; k++) begin
      if (k == inj) begin
        start = 1'b1; dividend = 9; divisor = 3; is_signed = 1'b0;
      end
      tick;
      start = 1'b0;
      chk("busy_run", W'(busy), W'(1));
      chk("done_run", W'(done), W'(0));
    end
    tick;
    chk("done_pulse", W'(done), W'(1));
    chk("busy_done",  W'(busy), W'(0));
    chk("quotient",   quotient, eq);
    chk("remainder",  remainder, er);
    chk("div_by_zero", W'(div_by_zero), W'(edz));
    last_q = eq; last_r = er; last_dz = edz;
    if (linger) begin
      tick;
      chk("done_low", W'(done), W'(0));
      chk("busy_idle", W'(busy), W'(0));
      chk("hold_q", quotient, eq);
      chk("hold_r", remainder, er);
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_q"}, quotient, last_q);
    chk({tag, "_r"}, remainder, last_r);
    chk({tag, "_dz"}, W'(div_by_zero), W'(last_dz));
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit           s;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    dividend = '0; divisor = '0;
    #3;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    chk_held("reset");
    tick; tick;
    reset = 1'b0;
    tick;

    // Directed corner cases.
    start_op(100, 7, 0);                   finish_op(100, 7, 0, 0, 1);
    start_op(32'hFFFFFFF9, 2, 1);          finish_op(32'hFFFFFFF9, 2, 1, 0, 1);
    chk("neg7_div2_q", quotient, 32'hFFFFFFFD);
    chk("neg7_div2_r", remainder, 32'hFFFFFFFF);
    start_op(5, 0, 0);                     finish_op(5, 0, 0, 0, 1);
    start_op(32'hFFFFFFFB, 0, 1);          finish_op(32'hFFFFFFFB, 0, 1, 0, 1);
    start_op(32'h80000000, 32'hFFFFFFFF, 1); finish_op(32'h80000000, 32'hFFFFFFFF, 1, 0, 1);
    chk("min_div_m1_q", quotient, 32'h80000000);
    start_op(32'hFFFFFFFF, 1, 0);          finish_op(32'hFFFFFFFF, 1, 0, 0, 1);
    start_op(7, 100, 1);                   finish_op(7, 100, 1, 0, 1);

    // Randomized operands.
    for (int n = 0; n < 16; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2, 3:    b = W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      start_op(a, b, s);
      finish_op(a, b, s, 0, 1);
    end

    // Flush at edge 10, then a fresh start at edge 12.
    start_op(100, 7, 0);
    for (int k = 1; k <= 9; k++) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk_held("flush_e10");
    tick;
    chk_held("flush_e11");
    start_op(100, 7, 0);                   finish_op(100, 7, 0, 0, 1);

    // Flush on the fix-up edge: no done, old results kept.
    start_op(1000, 3, 0);
    for (int k = 1; k <= W; k++) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk_held("flush_fix");

    // Flush wins over a simultaneous start.
    start = 1'b1; flush = 1'b1; dividend = 50; divisor = 5;
    tick;
    start = 1'b0; flush = 1'b0;
    chk_held("flush_start");
    tick;
    chk_held("flush_start2");

    // Asynchronous reset mid-run.
    start_op(100, 7, 0);
    for (int k = 1; k <= 5; k++) tick;
    reset = 1'b1;
    #1;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    chk_held("async_reset");
    #2;
    reset = 1'b0;

    // Start while busy is ignored; start in DONE is accepted back-to-back.
    start_op(100, 7, 0);
    finish_op(100, 7, 0, 6, 0);
    start_op(9, 3, 0);
    finish_op(9, 3, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_divider.md
MULTICYCLE_DIVIDER -- requirements
Module: multicycle_divider

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand/result width in bits; legal values are 2..64.
REQ-002 The block SHALL take parameter SIGNED_EN, default 1; when 0, is_signed is ignored and all operations are unsigned.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request a division; sampled at rising edge.
REQ-007 is_signed  input  1  two's-complement operation when high (DIV), unsigned when low (DIVU).
REQ-008 dividend  input  WIDTH  numerator, sampled with start.
REQ-009 divisor  input  WIDTH  denominator, sampled with start.
REQ-010 flush  input  1  abort any operation in progress (hazard-unit FlushE or branch squash).
REQ-011 busy  output  1  high while an accepted operation has not yet completed; drives a stall request.
REQ-012 done  output  1  single-cycle pulse: quotient/remainder are newly valid.
REQ-013 quotient  output  WIDTH  result destined for LO.
REQ-014 remainder  output  WIDTH  result destined for HI.
REQ-015 div_by_zero  output  1  high with results when the latched divisor was zero.

Function
REQ-016 The block SHALL implement the states IDLE, RUN, FIX and DONE.
REQ-017 In IDLE or DONE, start=1 and flush=0 at an edge SHALL latch the operands and mode, load |dividend| and |divisor| (unsigned magnitudes when signed), set the counter to WIDTH and enter RUN.
REQ-018 RUN SHALL perform one restoring shift-subtract step per edge, producing one quotient bit per step, and SHALL decrement the counter each step.
REQ-019 RUN SHALL go to FIX on the edge that performs the final (WIDTH-th) step.
REQ-020 FIX SHALL, in one edge, negate the quotient when the operand signs differ and negate the remainder when the dividend is negative (signed mode only), register the outputs, and enter DONE.
REQ-021 done SHALL be high exactly while in DONE (one cycle); the start edge is edge 0, so done is high in the cycle after edge WIDTH+1.
REQ-022 DONE SHALL go to IDLE on the next edge unless a new start is accepted per REQ-017.
REQ-023 busy SHALL be high in RUN and FIX and low in IDLE and DONE.
REQ-024 start in RUN or FIX SHALL be ignored, with no effect on state or outputs.
REQ-025 quotient, remainder and div_by_zero SHALL hold their last registered values until the next FIX.
REQ-026 Divisor zero SHALL use the same latency and SHALL yield quotient = all ones, remainder = original dividend and div_by_zero = 1, in both modes.
REQ-027 Signed most-negative / -1 SHALL yield quotient = most-negative value and remainder = 0, with no flag.
REQ-028 flush=1 at an edge SHALL force IDLE, SHALL suppress done, and SHALL leave the result outputs unchanged.
REQ-029 flush SHALL take priority over a simultaneous start, which SHALL be discarded.
REQ-030 All arithmetic SHALL use a WIDTH+1-bit partial remainder so that no intermediate result overflows.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter, at any point in an operation.
REQ-032 After reset deasserts, the first start SHALL be accepted normally.

Structure
REQ-033 The state encodings (IDLE=0, RUN=1, FIX=2, DONE=3) SHALL be defined in a shared include header with an include guard, for reuse by the hazard unit and the bench.
REQ-034 The counter width SHALL be $clog2(WIDTH+1), computed locally.
REQ-035 One sub-module, div_sign_fix (combinational magnitude/negate helper), SHALL be used in both the load and FIX steps; no other hierarchy is required.

Verification (WIDTH=32)
REQ-036 Unsigned 100/7 SHALL give quotient=14, remainder=2, done in the cycle after edge 33, and busy high for edges 1..32.
REQ-037 Signed 0xFFFFFFF9/2 (-7/2) SHALL give quotient=0xFFFFFFFD and remainder=0xFFFFFFFF.
REQ-038 Unsigned 5/0 SHALL give quotient=0xFFFFFFFF, remainder=5 and div_by_zero=1, at the same latency as REQ-036.
REQ-039 Signed 0x80000000/0xFFFFFFFF SHALL give quotient=0x80000000, remainder=0 and div_by_zero=0.
REQ-040 Start 100/7, then flush at edge 10, SHALL give busy=0 after edge 10, no done pulse and unchanged outputs; a start at edge 12 SHALL then complete normally.
REQ-041 Start 100/7, then reset mid-RUN, SHALL immediately zero all outputs; a start 9/3 while busy SHALL be ignored, and a start 9/3 issued during DONE SHALL be accepted back-to-back, giving quotient=3 and remainder=0.
